// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: default word width, the NOP encoding and the
// {pc, instr} entry layout used by the IF/ID and ID/EXE pipeline registers.
package arm_pkg;

    localparam int ARM_WORD_W = 32;
    localparam logic [ARM_WORD_W-1:0] ARM_NOP = 32'hE1A0_0000;  // MOV r0,r0

    typedef struct packed {
        logic [ARM_WORD_W-1:0] pc;
        logic [ARM_WORD_W-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Register-array storage for the IF/ID buffer: one write port and one
// asynchronous read port. Contents are not reset.
module if_id_fifo_mem #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [2*WORD_W-1:0]   wr_data,
    input  logic [PTR_W-1:0]      rd_ptr,
    output logic [2*WORD_W-1:0]   rd_data
);

    logic [2*WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF->ID decoupling buffer: holds up to DEPTH {PC+4, instr} pairs and discards
// them on flush. Define IF_ID_PERF_CNT_EN to build the stall/flush counters.
module if_id_fetch_buffer
    import arm_pkg::*;
#(
    parameter int WORD_W = ARM_WORD_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [WORD_W-1:0] if_pc,
    input  logic [WORD_W-1:0] if_instr,
    output logic              if_ready,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_instr,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic                push;
    logic                pop;
    logic [2*WORD_W-1:0] rd_data;

    // Handshakes depend only on registered count, never on id_ready/if_valid paths.
    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    if_id_fifo_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data ({if_pc, if_instr}),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    // An empty buffer presents a NOP so a careless ID stage decodes harmlessly.
    assign id_pc    = id_valid ? rd_data[2*WORD_W-1:WORD_W] : '0;
    assign id_instr = id_valid ? rd_data[WORD_W-1:0]        : WORD_W'(ARM_NOP);

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flush_q} + 33'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_valid && !id_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush) begin
                flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed self-checking bench for if_id_fetch_buffer (DEPTH=2).
module tb_if_id_fetch_buffer;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_fetch_buffer #(.WORD_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .flush     (flush),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
    endtask

    task automatic check_perf(input string tag, input logic [31:0] st, input logic [31:0] fl);
`ifdef IF_ID_PERF_CNT_EN
        chk({tag, "_stall"}, 64'(stall_cnt), 64'(st));
        chk({tag, "_flush"}, 64'(flush_cnt), 64'(fl));
`else
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_flush"}, 64'(flush_cnt), 64'd0);
`endif
    endtask

    logic [31:0] exp_q[$];
    int          model_cnt;
    int          sent;
    int          rcvd;
    int          hold;
    int          k;
    logic        do_push;
    logic        do_pop;

    initial begin
        // Reset state
        #3;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_pc",    64'(id_pc),    64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'(ARM_NOP));
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        check_perf("rst", 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: single word, no bypass, consumed next cycle
        id_ready = 1'b1;
        drive(1'b1, 32'h4, 32'hE3A0_1005);
        chk("t1_no_bypass", 64'(id_valid), 64'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t1_valid", 64'(id_valid), 64'd1);
        chk("t1_pc",    64'(id_pc),    64'h4);
        chk("t1_instr", 64'(id_instr), 64'hE3A0_1005);
        tick();
        chk("t1_empty", 64'(id_valid), 64'd0);
        chk("t1_nop",   64'(id_instr), 64'(ARM_NOP));

        // T2: fill with ID frozen, third word held by IF, then drain in order
        id_ready = 1'b0;
        drive(1'b1, 32'h8, 32'hE3A0_1001);
        tick();
        chk("t2_ready1", 64'(if_ready), 64'd1);
        drive(1'b1, 32'hC, 32'hE3A0_2002);
        tick();
        chk("t2_full", 64'(if_ready), 64'd0);
        drive(1'b1, 32'h10, 32'hE3A0_3003);
        tick();
        chk("t2_full_hold", 64'(if_ready), 64'd0);
        chk("t2_head1",     64'(id_instr), 64'hE3A0_1001);
        chk("t2_pc1",       64'(id_pc),    64'h8);
        id_ready = 1'b1;
        tick();
        chk("t2_head2",  64'(id_instr), 64'hE3A0_2002);
        chk("t2_ready2", 64'(if_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t2_head3", 64'(id_instr), 64'hE3A0_3003);
        chk("t2_pc3",   64'(id_pc),    64'h10);
        tick();
        chk("t2_drained", 64'(id_valid), 64'd0);

        // T3: flush with two entries stored and a word arriving
        do_reset();
        id_ready = 1'b0;
        drive(1'b1, 32'h20, 32'hE3A0_4004);
        tick();
        drive(1'b1, 32'h24, 32'hE3A0_5005);
        tick();
        drive(1'b1, 32'h28, 32'hE3A0_6006);
        flush = 1'b1;
        chk("t3_old_valid", 64'(id_valid), 64'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("t3_valid", 64'(id_valid), 64'd0);
        chk("t3_ready", 64'(if_ready), 64'd1);
        chk("t3_nop",   64'(id_instr), 64'(ARM_NOP));
        check_perf("t3", 32'd2, 32'd2);
        tick();
        chk("t3_dropped", 64'(id_valid), 64'd0);

        // T6: stall counter over 7 frozen cycles
        do_reset();
        id_ready = 1'b0;
        drive(1'b1, 32'h30, 32'hE3A0_7007);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        repeat (7) tick();
        check_perf("t6", 32'd7, 32'd0);
        id_ready = 1'b1;
        tick();
        chk("t6_popped", 64'(id_valid), 64'd0);

        // T5: async reset between edges empties a full buffer
        id_ready = 1'b0;
        drive(1'b1, 32'h40, 32'hE3A0_8008);
        tick();
        drive(1'b1, 32'h44, 32'hE3A0_9009);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t5_full", 64'(if_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(id_valid), 64'd0);
        chk("t5_ready", 64'(if_ready), 64'd1);
        chk("t5_nop",   64'(id_instr), 64'(ARM_NOP));
        rst_n = 1'b1;
        tick();

        // T4: 20-word stream with id_ready toggling every 1-3 cycles
        exp_q.delete();
        model_cnt = 0;
        sent = 0;
        rcvd = 0;
        hold = 1;
        k = 0;
        id_ready = 1'b0;
        for (int cyc = 0; cyc < 300 && rcvd < 20; cyc++) begin
            if (id_valid !== (model_cnt != 0) || if_ready !== (model_cnt != 2)) begin
                chk("t4_valid", 64'(id_valid), 64'(model_cnt != 0));
                chk("t4_ready", 64'(if_ready), 64'(model_cnt != 2));
            end
            hold--;
            if (hold == 0) begin
                id_ready = ~id_ready;
                k++;
                hold = (k % 3) + 1;
            end
            if (sent < 20) drive(1'b1, 32'(4 * (sent + 1)), 32'hE3A0_0000 + 32'(sent));
            else           drive(1'b0, 32'h0, 32'h0);
            do_push = if_valid && (model_cnt < 2);
            do_pop  = id_ready && (model_cnt > 0);
            if (do_pop) begin
                chk("t4_instr", 64'(id_instr), 64'hE3A0_0000 + 64'(exp_q[0]));
                chk("t4_pc",    64'(id_pc),    64'(4 * (exp_q[0] + 1)));
                void'(exp_q.pop_front());
                rcvd++;
                model_cnt--;
            end
            if (do_push) begin
                exp_q.push_back(32'(sent));
                sent++;
                model_cnt++;
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        chk("t4_rcvd", 64'(rcvd), 64'd20);
        chk("t4_empty", 64'(id_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
